// File: rtl/axi_pkg.sv
// Shared AXI write-slave types, plus fallback channel widths matching AXI_define.svh.
// The bound-check option is selected by AXI_WR_BOUND_CHECK_EN.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_BURST_BITS
`define AXI_BURST_BITS 2
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } wr_state_t;

    localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/axi_wr_slave_addr_gen.sv
// Beat counter and word-address stepping for one write burst.
// With AXI_WR_BOUND_CHECK_EN the address saturates and flags words >= DEPTH.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int DEPTH = 16384,
    parameter int WW    = 30,
    parameter int LW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [WW-1:0] start_addr,
    input  logic [LW-1:0] len,
    input  logic          fixed,
    input  logic          step,
    output logic [WW-1:0] addr,
    output logic          last_beat,
    output logic          out_of_range
);

`ifdef AXI_WR_BOUND_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic [LW-1:0] cnt_q;
    logic [LW-1:0] len_q;
    logic          fixed_q;
    logic [WW-1:0] addr_q;
    logic [WW-1:0] addr_inc;

    // Saturation keeps an out-of-range burst from wrapping back into range.
    assign addr_inc     = (CHECK && (&addr_q)) ? addr_q : addr_q + 1'b1;
    assign out_of_range = CHECK && (addr_q >= WW'(DEPTH));
    assign last_beat    = (cnt_q == len_q);
    assign addr         = addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            len_q   <= '0;
            fixed_q <= 1'b0;
            addr_q  <= '0;
        end else if (load) begin
            cnt_q   <= '0;
            len_q   <= len;
            fixed_q <= fixed;
            addr_q  <= start_addr;
        end else if (step) begin
            cnt_q <= cnt_q + 1'b1;
            if (!fixed_q) addr_q <= addr_inc;
        end
    end

endmodule

// File: rtl/axi_wr_slave.sv
// AXI4 write responder: one burst at a time into a single-port word memory.
// Optional address range checking is enabled by AXI_WR_BOUND_CHECK_EN.
module axi_wr_slave
    import axi_pkg::*;
#(
    parameter int DEPTH         = 16384,
    parameter int BASE_WORD_LSB = 2,
    localparam int AW_MEM       = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [`AXI_IDS_BITS-1:0]   awid_i,
    input  logic [`AXI_ADDR_BITS-1:0]  awaddr_i,
    input  logic [`AXI_LEN_BITS-1:0]   awlen_i,
    input  logic [`AXI_SIZE_BITS-1:0]  awsize_i,
    input  logic [`AXI_BURST_BITS-1:0] awburst_i,
    input  logic                       awvalid_i,
    output logic                       awready_o,
    input  logic [`AXI_DATA_BITS-1:0]  wdata_i,
    input  logic [`AXI_STRB_BITS-1:0]  wstrb_i,
    input  logic                       wlast_i,
    input  logic                       wvalid_i,
    output logic                       wready_o,
    output logic [`AXI_IDS_BITS-1:0]   bid_o,
    output logic [1:0]                 bresp_o,
    output logic                       bvalid_o,
    input  logic                       bready_i,
    output logic                       mem_we_o,
    output logic [AW_MEM-1:0]          mem_addr_o,
    output logic [3:0]                 mem_wstrb_o,
    output logic [31:0]                mem_wdata_o
);

    localparam int WW = `AXI_ADDR_BITS - BASE_WORD_LSB;

    wr_state_t                state_q, state_d;
    logic                     aw_en_q;
    logic [`AXI_IDS_BITS-1:0] id_q;
    logic                     err_q;
    logic                     size_bad_q;
    logic                     unsup_q;
    logic                     aw_hs, w_hs;
    logic                     beat_err;
    logic [WW-1:0]            gen_addr;
    logic                     last_beat, oob;
    logic                     size_bad, unsup;
    logic                     unused_bits;

    assign size_bad = (awsize_i != SIZE_WORD);
    assign unsup    = !((awburst_i == BURST_FIXED) || (awburst_i == BURST_INCR));

    axi_burst_addr_gen #(
        .DEPTH(DEPTH),
        .WW   (WW),
        .LW   (`AXI_LEN_BITS)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load        (aw_hs),
        .start_addr  (awaddr_i[`AXI_ADDR_BITS-1:BASE_WORD_LSB]),
        .len         (awlen_i),
        .fixed       (awburst_i == BURST_FIXED),
        .step        (w_hs),
        .addr        (gen_addr),
        .last_beat   (last_beat),
        .out_of_range(oob)
    );

    always_comb begin
        state_d   = state_q;
        awready_o = 1'b0;
        wready_o  = 1'b0;
        bvalid_o  = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                awready_o = aw_en_q;
                aw_hs     = awvalid_i & aw_en_q;
                if (aw_hs) state_d = ST_DATA;
            end
            ST_DATA: begin
                wready_o = 1'b1;
                w_hs     = wvalid_i;
                if (w_hs && last_beat) state_d = ST_RESP;
            end
            ST_RESP: begin
                bvalid_o = 1'b1;
                if (bready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The counter alone ends the burst; a wlast disagreement only marks it bad.
    assign beat_err = w_hs & ((wlast_i != last_beat) | oob | unsup_q);

    assign mem_we_o    = w_hs & ~size_bad_q & ~unsup_q & ~oob;
    assign mem_addr_o  = w_hs ? gen_addr[AW_MEM-1:0] : '0;
    assign mem_wstrb_o = w_hs ? wstrb_i : '0;
    assign mem_wdata_o = w_hs ? wdata_i : '0;

    assign bid_o   = bvalid_o ? id_q : '0;
    assign bresp_o = (bvalid_o && err_q) ? RESP_SLVERR : RESP_OKAY;

    assign unused_bits = ^{awaddr_i[BASE_WORD_LSB-1:0], gen_addr[WW-1:AW_MEM]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            aw_en_q    <= 1'b0;
            id_q       <= '0;
            err_q      <= 1'b0;
            size_bad_q <= 1'b0;
            unsup_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            aw_en_q <= 1'b1;
            if (aw_hs) begin
                id_q       <= awid_i;
                size_bad_q <= size_bad;
                unsup_q    <= unsup;
                err_q      <= size_bad | unsup;
            end else if (beat_err) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_slave.sv
// Randomized scoreboard bench for axi_wr_slave.
// Expected writes and B responses are queued at issue and checked by a monitor.
module tb_axi_wr_slave;

    localparam int DEPTH = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  awid_i = '0;
    logic [31:0] awaddr_i = '0;
    logic [7:0]  awlen_i = '0;
    logic [2:0]  awsize_i = '0;
    logic [1:0]  awburst_i = '0;
    logic        awvalid_i = 1'b0;
    logic        awready_o;
    logic [31:0] wdata_i = '0;
    logic [3:0]  wstrb_i = '0;
    logic        wlast_i = 1'b0;
    logic        wvalid_i = 1'b0;
    logic        wready_o;
    logic [7:0]  bid_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i = 1'b0;
    logic        mem_we_o;
    logic [13:0] mem_addr_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_wdata_o;

    axi_wr_slave #(.DEPTH(DEPTH), .BASE_WORD_LSB(2)) dut (
        .clk(clk), .rst(rst),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i),
        .awsize_i(awsize_i), .awburst_i(awburst_i),
        .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o),
        .bvalid_o(bvalid_o), .bready_i(bready_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    typedef struct {
        logic [7:0] id;
        logic [1:0] resp;
        int         beats;
    } b_t;

    wr_t wq[$];
    b_t  bq[$];
    int  errors = 0;
    int  checks = 0;
    int  bready_mode = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Ready-side pressure: random, held low, or held high.
    initial forever begin
        @(posedge clk);
        #1;
        if (bready_mode == 1) bready_i = 1'b0;
        else if (bready_mode == 2) bready_i = 1'b1;
        else bready_i = 1'($urandom_range(0, 1));
    end

    bit         aw_p, wd_p, b_p, st_p, wd;
    logic [7:0] hid;
    logic [1:0] hresp;
    int         wcnt;
    wr_t        ew;
    b_t         eb;

    always @(negedge clk) begin
        if (!rst) begin
            aw_p = 0; wd_p = 0; b_p = 0; st_p = 0; wcnt = 0;
        end else begin
            if (aw_p) chk("wready_after_aw", 64'(wready_o), 64'd1);
            if (wd_p) begin
                chk("bvalid_after_last", 64'(bvalid_o), 64'd1);
                chk("wready_after_last", 64'(wready_o), 64'd0);
            end
            if (b_p) chk("awready_after_b", 64'(awready_o), 64'd1);
            if (st_p) begin
                chk("b_hold_valid", 64'(bvalid_o), 64'd1);
                chk("b_hold_id", 64'(bid_o), 64'(hid));
                chk("b_hold_resp", 64'(bresp_o), 64'(hresp));
            end
            if (bvalid_o) chk("aw_blocked_resp", 64'(awready_o), 64'd0);
            if (mem_we_o) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write addr=%0h", mem_addr_o);
                end else begin
                    ew = wq.pop_front();
                    chk("wr_addr", 64'(mem_addr_o), 64'(ew.addr));
                    chk("wr_data", 64'(mem_wdata_o), 64'(ew.data));
                    chk("wr_strb", 64'(mem_wstrb_o), 64'(ew.strb));
                end
            end
            wd = 0;
            if (wvalid_i && wready_o) begin
                wcnt++;
                if (bq.size() > 0 && wcnt == bq[0].beats) begin
                    wd = 1;
                    wcnt = 0;
                end
            end
            if (bvalid_o && bready_i) begin
                if (bq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_b id=%0h", bid_o);
                end else begin
                    eb = bq.pop_front();
                    chk("b_id", 64'(bid_o), 64'(eb.id));
                    chk("b_resp", 64'(bresp_o), 64'(eb.resp));
                end
            end
            st_p  = bvalid_o && !bready_i;
            hid   = bid_o;
            hresp = bresp_o;
            aw_p  = awvalid_i && awready_o;
            b_p   = bvalid_o && bready_i;
            wd_p  = wd;
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_awready"}, 64'(awready_o), 64'd0);
        chk({tag, "_wready"}, 64'(wready_o), 64'd0);
        chk({tag, "_bvalid"}, 64'(bvalid_o), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we_o), 64'd0);
        chk({tag, "_bresp"}, 64'(bresp_o), 64'd0);
        chk({tag, "_bid"}, 64'(bid_o), 64'd0);
    endtask

    // Issue one burst; expectations come from the address/burst rules directly.
    task automatic issue(input logic [7:0] id, input logic [31:0] addr,
                         input int len, input logic [1:0] burst,
                         input logic [2:0] size, input int bad_last,
                         input int abort_at);
        logic [31:0] d[16];
        logic [3:0]  s[16];
        logic        lst[16];
        longint      word, a;
        bit          err, we;
        int          n;
        word = longint'(addr >> 2);
        err  = (size != 3'b010) || (burst > 2'd1);
        for (int i = 0; i <= len; i++) begin
            d[i]   = $urandom;
            s[i]   = 4'($urandom_range(1, 15));
            lst[i] = (i == len) ^ (i == bad_last);
            if (lst[i] != (i == len)) err = 1;
            a  = (burst == 2'd0) ? word : word + i;
            we = (size == 3'b010) && (burst <= 2'd1);
`ifdef AXI_WR_BOUND_CHECK_EN
            if (a >= DEPTH) begin
                we  = 0;
                err = 1;
            end
`endif
            if (we && (abort_at < 0 || i < abort_at))
                wq.push_back('{14'(a % DEPTH), d[i], s[i]});
        end
        if (abort_at < 0) bq.push_back('{id, err ? 2'd2 : 2'd0, len + 1});

        awid_i = id; awaddr_i = addr; awlen_i = 8'(len);
        awsize_i = size; awburst_i = burst; awvalid_i = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready_o && n < 400);
        chk("aw_accept", 64'(awready_o), 64'd1);
        @(posedge clk);
        #1;
        awvalid_i = 1'b0;

        for (int i = 0; i <= len; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            wvalid_i = 1'b1; wdata_i = d[i]; wstrb_i = s[i]; wlast_i = lst[i];
            if (i == abort_at) begin
                #2;
                rst = 1'b0;
                #1;
                chk_idle_outputs("abort");
                wvalid_i = 1'b0; wlast_i = 1'b0;
                repeat (2) @(posedge clk);
                #3;
                rst = 1'b1;
                #1;
                chk("release_awready_low", 64'(awready_o), 64'd0);
                @(posedge clk);
                #1;
                chk("release_awready_high", 64'(awready_o), 64'd1);
                return;
            end
            n = 0;
            do begin @(negedge clk); n++; end while (!wready_o && n < 400);
            chk("w_accept", 64'(wready_o), 64'd1);
            @(posedge clk);
            #1;
            wvalid_i = 1'b0; wlast_i = 1'b0;
        end
    endtask

    initial begin
        int         n, len, r;
        logic [1:0] burst;
        logic [2:0] size;
        logic [31:0] word;

        #3;
        chk_idle_outputs("reset");
        #9;
        rst = 1'b1;
        #1;
        chk("first_edge_awready_low", 64'(awready_o), 64'd0);
        @(posedge clk);
        #1;
        chk("first_edge_awready_high", 64'(awready_o), 64'd1);

        issue(8'h15, 32'h100, 3, 2'd1, 3'b010, -1, -1);
        issue(8'h21, 32'h20, 2, 2'd0, 3'b010, -1, -1);
        issue(8'h33, 32'h40, 1, 2'd1, 3'b010, 0, -1);

        bready_mode = 1;
        issue(8'h44, 32'h80, 0, 2'd1, 3'b010, -1, -1);
        fork
            issue(8'h45, 32'h84, 1, 2'd1, 3'b010, -1, -1);
            begin
                repeat (6) @(posedge clk);
                bready_mode = 2;
                repeat (3) @(posedge clk);
                bready_mode = 0;
            end
        join

        issue(8'h50, 32'((DEPTH - 1) * 4), 1, 2'd1, 3'b010, -1, -1);
        issue(8'h51, 32'h300, 1, 2'd2, 3'b010, -1, -1);
        issue(8'h52, 32'h304, 1, 2'd1, 3'b011, -1, -1);
        issue(8'h60, 32'h200, 7, 2'd1, 3'b010, -1, 2);
        issue(8'h61, 32'h400, 2, 2'd1, 3'b010, -1, -1);

        for (int k = 0; k < 40; k++) begin
            len = $urandom_range(0, 7);
            r   = $urandom_range(0, 9);
            burst = (r < 5) ? 2'd1 : (r < 9) ? 2'd0 : 2'd2;
            size  = ($urandom_range(0, 9) == 0) ? 3'b001 : 3'b010;
            case ($urandom_range(0, 3))
                0: word = 32'($urandom_range(0, 63));
                1: word = 32'($urandom_range(DEPTH - 4, DEPTH - 1));
                2: word = 32'($urandom) & 32'h3FFF_FFFF;
                default: word = 32'($urandom_range(0, DEPTH - 1));
            endcase
            issue(8'($urandom), {word[29:0], 2'($urandom)}, len, burst, size,
                  ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1, -1);
        end

        n = 0;
        while (bq.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        chk("drain_b", 64'(bq.size()), 64'd0);
        chk("drain_w", 64'(wq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
